scan_multiplexer: RTL and testbench

Registered, parametrised N-channel, W-bit multiplexer with a one-entry valid/ready output buffer. It has two modes. In manual mode it captures the channel named by `sel`. In auto-scan mode it round-robins over the enabled channels. It replaces the fixed 1-bit 8:1 combinational mux wherever a sampled, back-pressurable channel stream is needed.

---
 rtl/scan_multiplexer.sv | 109 ++++++++++
 tb/tb_scan_multiplexer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_multiplexer.sv
// rtl/scan_multiplexer.sv - registered N-channel mux with manual/auto-scan capture and a one-entry valid/ready buffer
module scan_multiplexer #(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    din,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic [N-1:0]      chan_en,
  input  logic              req,
  output logic              req_ready,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   y_ch,
  output logic              y_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  localparam logic [SELW:0]   N_W  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [W-1:0]    y_q, y_d;
  logic [SELW-1:0] y_ch_q, y_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            y_valid_q, y_valid_d;
  logic            sel_err_q, sel_err_d;

  logic            cap;
  logic            sel_ok;
  logic            scan_hit;
  logic            do_cap;
  logic [SELW-1:0] scan_ch;
  logic [SELW-1:0] scan_nxt;
  logic [SELW-1:0] scan_idx;
  logic [SELW-1:0] cap_ch;
  logic [W-1:0]    cap_data;

  assign cap    = !y_valid_q || out_ready;
  assign sel_ok = {1'b0, sel} < N_W;

  // Round-robin search starting at ptr; index wraps at N, not at 2^SELW.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = '0;
    scan_idx = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!scan_hit && chan_en[scan_idx]) begin
        scan_hit = 1'b1;
        scan_ch  = scan_idx;
      end
      scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
    scan_nxt = (scan_ch == LAST) ? '0 : scan_ch + 1'b1;
  end

  always_comb begin
    cap_ch   = mode ? scan_ch : sel;
    do_cap   = req && (mode ? scan_hit : sel_ok);
    cap_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cap_ch == SELW'(k)) cap_data = din[k*W +: W];
    end
  end

  always_comb begin
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    ptr_d     = ptr_q;
    y_valid_d = y_valid_q;
    sel_err_d = 1'b0;
    if (cap) begin
      if (do_cap) begin
        y_d       = cap_data;
        y_ch_d    = cap_ch;
        y_valid_d = 1'b1;
        if (mode) ptr_d = scan_nxt;
      end else begin
        y_valid_d = 1'b0;
        sel_err_d = req && !mode && !sel_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      ptr_q     <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign req_ready = cap;
  assign y         = y_q;
  assign y_ch      = y_ch_q;
  assign y_valid   = y_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_scan_multiplexer.sv
// tb/tb_scan_multiplexer.sv - self-checking bench for scan_multiplexer (N=8 and N=6 instances, W=4)
module tb_scan_multiplexer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        rst8, mode8, req8, ordy8, rr8, v8, err8;
  logic [2:0]  sel8, ch8;
  logic [7:0]  en8;
  logic [31:0] din8;
  logic [3:0]  y8;

  // N=6 instance
  logic        rst6, mode6, req6, ordy6, rr6, v6, err6;
  logic [2:0]  sel6, ch6;
  logic [5:0]  en6;
  logic [23:0] din6;
  logic [3:0]  y6;

  scan_multiplexer #(.N(8), .W(4)) dut8 (
    .clk(clk), .rst(rst8), .din(din8), .sel(sel8), .mode(mode8), .chan_en(en8),
    .req(req8), .req_ready(rr8), .y(y8), .y_ch(ch8), .y_valid(v8),
    .out_ready(ordy8), .sel_err(err8)
  );

  scan_multiplexer #(.N(6), .W(4)) dut6 (
    .clk(clk), .rst(rst6), .din(din6), .sel(sel6), .mode(mode6), .chan_en(en6),
    .req(req6), .req_ready(rr6), .y(y6), .y_ch(ch6), .y_valid(v6),
    .out_ready(ordy6), .sel_err(err6)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         mode;
    logic [2:0] sel;
    logic [7:0] en;
    bit         req;
    bit         ordy;
    int         rr;   // -1 = not checked
    int         y;
    int         ch;
    int         v;
    int         err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit m, input int s, input int e, input bit rq, input bit o,
                     input int rr, input int yy, input int c, input int vv, input int er);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = 3'(s); t.en = 8'(e); t.req = rq; t.ordy = o;
    t.rr = rr; t.y = yy; t.ch = c; t.v = vv; t.err = er;
    tbl.push_back(t);
  endtask

  // Reference model: state described as the observable buffer plus scan position.
  typedef struct {
    int y;
    int ch;
    int v;
    int err;
    int ptr;
  } mstate_t;

  function automatic mstate_t step(input int n, input mstate_t s, input bit r, input bit m,
                                   input int sl, input logic [7:0] en, input bit rq,
                                   input bit o, input logic [31:0] d);
    mstate_t nx;
    int pick;
    int c;
    nx = s;
    nx.err = 0;
    pick = -1;
    if (r) begin
      nx = '{default: 0};
      return nx;
    end
    if (s.v == 0 || o) begin
      if (rq && !m) begin
        if (sl < n) pick = sl;
        else nx.err = 1;
      end else if (rq) begin
        for (int i = 0; i < n; i++) begin
          c = (s.ptr + i) % n;
          if (pick < 0 && en[c]) pick = c;
        end
      end
      if (pick >= 0) begin
        nx.v  = 1;
        nx.ch = pick;
        nx.y  = int'((d >> (4 * pick)) & 32'hF);
        if (m) nx.ptr = (pick + 1) % n;
      end else begin
        nx.v = 0;
      end
    end
    return nx;
  endfunction

  mstate_t m8, m6, n8, n6;

  initial begin
    rst8 = 1; mode8 = 0; req8 = 0; ordy8 = 0; sel8 = 0; en8 = 0; din8 = 0;
    rst6 = 1; mode6 = 0; req6 = 0; ordy6 = 0; sel6 = 0; en6 = 0; din6 = 0;
    for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k + 3);

    // rst mode sel en req ordy | rr y ch v err
    add(1, 0, 3, 'h5A, 1, 1, -1,  0, 0, 0, 0);
    add(1, 1, 6, 'hC3, 1, 0,  1,  0, 0, 0, 0);
    add(0, 0, 5, 'h00, 1, 1,  1,  8, 5, 1, 0);
    add(0, 0, 2, 'h00, 1, 0,  0,  8, 5, 1, 0);
    add(0, 0, 2, 'h00, 1, 0,  0,  8, 5, 1, 0);
    add(0, 0, 2, 'h00, 1, 1,  1,  5, 2, 1, 0);
    add(0, 0, 2, 'h00, 0, 1,  1,  5, 2, 0, 0);
    add(1, 0, 0, 'h00, 0, 1,  1,  0, 0, 0, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1,  4, 1, 1, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1,  5, 2, 1, 0);
    add(0, 1, 0, 'hA6, 1, 0,  0,  5, 2, 1, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1,  8, 5, 1, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1, 10, 7, 1, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1,  4, 1, 1, 0);
    add(0, 1, 0, 'hA6, 1, 1,  1,  5, 2, 1, 0);
    add(0, 1, 0, 'h00, 1, 1,  1,  5, 2, 0, 0);
    add(0, 1, 0, 'h80, 1, 1,  1, 10, 7, 1, 0);
    add(0, 1, 0, 'h81, 1, 1,  1,  3, 0, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  4, 1, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  5, 2, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  6, 3, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  7, 4, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  8, 5, 1, 0);
    add(1, 1, 0, 'hFF, 1, 1,  1,  0, 0, 0, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  3, 0, 1, 0);
    add(0, 0, 7, 'hFF, 1, 1,  1, 10, 7, 1, 0);
    add(0, 1, 0, 'hFF, 1, 1,  1,  4, 1, 1, 0);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst8 = tbl[i].rst; mode8 = tbl[i].mode; sel8 = tbl[i].sel; en8 = tbl[i].en;
      req8 = tbl[i].req; ordy8 = tbl[i].ordy;
      #1;
      if (tbl[i].rr >= 0) chk($sformatf("tbl%0d req_ready", i), int'(rr8), tbl[i].rr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d y", i), int'(y8), tbl[i].y);
      chk($sformatf("tbl%0d y_ch", i), int'(ch8), tbl[i].ch);
      chk($sformatf("tbl%0d y_valid", i), int'(v8), tbl[i].v);
      chk($sformatf("tbl%0d sel_err", i), int'(err8), tbl[i].err);
    end

    // N=6: out-of-range manual select, then full scan wrap
    for (int k = 0; k < 6; k++) din6[k*4 +: 4] = 4'(k + 1);
    rst6 = 1; @(posedge clk); #1;
    rst6 = 0; mode6 = 0; sel6 = 3'd6; req6 = 1; ordy6 = 1;
    @(posedge clk); #1;
    chk("n6 sel_err pulse", int'(err6), 1);
    chk("n6 sel_err no capture", int'(v6), 0);
    chk("n6 sel_err y", int'(y6), 0);
    req6 = 0;
    @(posedge clk); #1;
    chk("n6 sel_err one cycle", int'(err6), 0);
    mode6 = 1; en6 = 6'h3F; req6 = 1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("n6 scan%0d y_ch", i), int'(ch6), i % 6);
      chk($sformatf("n6 scan%0d y", i), int'(y6), (i % 6) + 1);
      chk($sformatf("n6 scan%0d sel_err", i), int'(err6), 0);
    end

    // Randomized run on both instances against the reference model
    m8 = '{default: 0};
    m6 = '{default: 0};
    for (int c = 0; c < 400; c++) begin
      rst8 = (c == 0) || ($urandom_range(0, 40) == 0);
      mode8 = 1'($urandom); sel8 = 3'($urandom); en8 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) en8 = 0;
      req8 = ($urandom_range(0, 3) != 0); ordy8 = ($urandom_range(0, 2) != 0);
      din8 = $urandom;
      rst6 = (c == 0) || ($urandom_range(0, 40) == 0);
      mode6 = 1'($urandom); sel6 = 3'($urandom); en6 = 6'($urandom);
      req6 = ($urandom_range(0, 3) != 0); ordy6 = ($urandom_range(0, 2) != 0);
      din6 = 24'($urandom);
      n8 = step(8, m8, rst8, mode8, int'(sel8), en8, req8, ordy8, din8);
      n6 = step(6, m6, rst6, mode6, int'(sel6), {2'b00, en6}, req6, ordy6, {8'h00, din6});
      #1;
      if (c > 0) begin
        chk($sformatf("rnd8 c%0d req_ready", c), int'(rr8), (m8.v == 0 || ordy8) ? 1 : 0);
        chk($sformatf("rnd6 c%0d req_ready", c), int'(rr6), (m6.v == 0 || ordy6) ? 1 : 0);
      end
      @(posedge clk); #1;
      m8 = n8;
      m6 = n6;
      chk($sformatf("rnd8 c%0d y", c), int'(y8), m8.y);
      chk($sformatf("rnd8 c%0d y_ch", c), int'(ch8), m8.ch);
      chk($sformatf("rnd8 c%0d y_valid", c), int'(v8), m8.v);
      chk($sformatf("rnd8 c%0d sel_err", c), int'(err8), m8.err);
      chk($sformatf("rnd6 c%0d y", c), int'(y6), m6.y);
      chk($sformatf("rnd6 c%0d y_ch", c), int'(ch6), m6.ch);
      chk($sformatf("rnd6 c%0d y_valid", c), int'(v6), m6.v);
      chk($sformatf("rnd6 c%0d sel_err", c), int'(err6), m6.err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
